instruction_fetch_controller: RTL and testbench
===============================================

// Module: instruction_fetch_controller
// PURPOSE
// - Sequences the instruction memory: drives its word index (sel), tracks the 1-cycle registered read,
//   and presents {pc, instr} pairs to decode over a valid/ready handshake.
// - Absorbs decode stalls via a small fetch buffer; services redirects (branch/jump) from execute.
// - Sits between instruction_memory and the decode stage of the CPU core.
// PARAMETERS
// - RESET_PC   32'h00000000  word index fetched first after reset
// - BUF_DEPTH  2             fetch buffer entries; >=2 required for 1 instr/cycle
// PORTS
// - clock            in   1   single clock, all state updates on posedge
// - reset            in   1   asynchronous, active-high; clears all state
// - run              in   1   1 = issue fetches; 0 = hold (no new issues)
// - imem_sel         out  32  word index to instruction_memory (sel)
// - imem_data        in   32  instruction_memory out; valid the cycle after its sel was driven
// - redirect_valid   in   1   single-cycle request to restart fetch at redirect_target
// - redirect_target  in   32  new word index
// - instr_valid      out  1   buffer head valid
// - instr_ready      in   1   decode accepts head this cycle
// - instr            out  32  head instruction
// - instr_pc         out  32  word index of head instruction
// - halted           out  1   run==0, nothing in flight, buffer empty
// BEHAVIOUR
// - Reset values: fetch_pc=RESET_PC, inflight=0, buffer empty, instr_valid=0, instr=0, instr_pc=0, halted=0.
// - imem_sel = redirect_valid ? redirect_target : fetch_pc (combinational; memory registers it).
// - pop = instr_valid & instr_ready. Issue when run & (count + inflight - pop) < BUF_DEPTH.
// - On issue: inflight<=1, inflight_pc<=imem_sel, fetch_pc<=imem_sel+1 (mod 2^32; 32'hFFFFFFFF -> 0).
// - No issue: inflight<=0, fetch_pc holds (or takes redirect_target if redirect_valid).
// - Cycle after an issue: imem_data is pushed with inflight_pc into the buffer.
//   imem_data in any other cycle is ignored (memory outputs every clock).
// - Latency: sel driven in cycle n -> data pushed at end of n+1 -> instr_valid in cycle n+2.
//   Steady state with instr_ready=1: one instruction per cycle, consecutive instr_pc.
// - Buffer: FIFO, head drives instr/instr_pc; instr/instr_pc hold while instr_valid & !instr_ready.
//   Push+pop same cycle allowed. The issue rule guarantees no push into a full buffer;
//   a push into a full buffer is an assertion failure.
// - Redirect (redirect_valid=1):
//   - Flush the buffer.
//   - Drop the in-flight response: the cycle-n+1 push is suppressed.
//   - Issue redirect_target in the same cycle if run=1. Otherwise fetch_pc<=redirect_target.
//   - A pop in the redirect cycle completes the handshake; the rest of the buffer is discarded.
//   - Back-to-back redirects: the last one wins; each cancels the previous in-flight fetch.
//   - First instr from target is valid in cycle n+2.
// - run deassert: no new issues; an in-flight response still lands; the buffer still drains.
//   run reassert resumes at fetch_pc.
// - FSM (2 states):
//   - RUNNING: run=1, issue per rule.
//   - HOLD: run=0. HOLD->RUNNING when run=1; RUNNING->HOLD when run=0.
//   - halted = HOLD & !inflight & count==0.
// - Reset mid-operation: everything clears immediately (async); the in-flight response is never pushed.
//   After release, resume from RESET_PC. Reset overrides redirect.
// STRUCTURE
// - Shared header cpu_defs.vh: ADDR_W=32, INSTR_W=32, RESET_PC default, opcode/funct constants
//   (OP_R, OP_BEQ, OP_BNE, OPR_ADD, ...) for bench encoding.
// - Sub-module fetch_buffer: parameterised FIFO of {pc, instr}.
//   Ports: push, pop, flush, count, head; reset to empty.
// - Top: issue logic, inflight/inflight_pc regs, fetch_pc reg, run FSM.
// TESTING (bench pairs DUT with instruction_memory, memory preloaded)
// - Reset release, run=1, ready=1 -> instr_valid first high 2 cycles after first edge;
//   instr_pc 0,1,2,3 on consecutive cycles with matching words.
// - ready=0 from the cycle instr_pc=1 is presented, for 5 cycles -> instr/instr_pc hold at pc 1;
//   imem_sel stops advancing at 3; no push on full.
//   Release -> pc 2,3,4 with no gap and no duplicate.
// - redirect_valid pulse, target=32'h00000000, while pc 3 is presented -> buffer flushed;
//   the response for pc 4 is dropped; instr_pc=0 two cycles later; pc 5 never appears.
// - Back-to-back redirects to 8 then 2 -> only pc 2,3,... appear; pc 8 is never presented.
// - run=0 mid-stream -> the in-flight word is delivered, the buffer drains, halted=1;
//   run=1 -> resumes at the next sequential pc.
// - Reset asserted asynchronously mid-clock with a fetch in flight -> outputs 0 immediately;
//   after release the first instr_pc=RESET_PC.
//   Separately, fetch_pc=32'hFFFFFFFF via redirect -> next pc 0.

Source files
------------

// File: rtl/instruction_fetch_controller_pkg.sv
// Shared types and constants for the instruction fetch controller and its fetch buffer.
// Opcode/funct constants are also used to build instruction words in benches.
package instruction_fetch_controller_pkg;

  localparam int ADDR_W = 32;
  localparam int INSTR_W = 32;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int DEFAULT_BUF_DEPTH = 2;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OPR_ADD = 6'h20;
  localparam logic [5:0] OPR_SUB = 6'h22;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    FETCH_RUNNING = 1'b0,
    FETCH_HOLD    = 1'b1
  } fetch_state_t;

  // Word index arithmetic wraps modulo 2^32.
  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return pc + 1'b1;
  endfunction

endpackage

// File: rtl/instruction_fetch_controller_fetch_buffer.sv
// Small FIFO of {pc, instr} pairs between the memory response and decode.
// Flush empties it in one cycle; head is the oldest entry.
module instruction_fetch_controller_fetch_buffer
  import instruction_fetch_controller_pkg::*;
#(
  parameter int DEPTH = DEFAULT_BUF_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  fetch_entry_t       push_entry,
  input  logic               pop,
  input  logic               flush,
  output logic [CNT_W-1:0]   count,
  output fetch_entry_t       head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= bump(wr_ptr);
      end
      if (pop) rd_ptr <= bump(rd_ptr);
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign count = cnt;
  assign head  = mem[rd_ptr];

  // The issue rule upstream must never let a response land in a full buffer.
  push_into_full: assert property (@(posedge clock) disable iff (reset)
    !(push && !flush && cnt == CNT_W'(DEPTH)))
    else $error("fetch buffer overflow");

endmodule

// File: rtl/instruction_fetch_controller.sv
// Drives the instruction memory word index, tracks the one-cycle registered read and
// feeds {pc, instr} to decode over valid/ready, with redirect and run/hold control.
module instruction_fetch_controller
  import instruction_fetch_controller_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int                BUF_DEPTH = DEFAULT_BUF_DEPTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  output logic [ADDR_W-1:0]  imem_sel,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               halted,
  output fetch_state_t       fsm_state
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  // Handshake: a transfer happens in any cycle where instr_valid and instr_ready are both
  // high; while instr_valid is high and instr_ready low, instr/instr_pc hold their value.

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic [CNT_W-1:0]  count;
  fetch_entry_t      head;
  fetch_entry_t      push_entry;
  logic              pop;
  logic              push;
  logic              issue;
  logic [OCC_W-1:0]  occupancy;

  assign imem_sel    = redirect_valid ? redirect_target : fetch_pc;
  assign instr_valid = (count != '0);
  assign pop         = instr_valid & instr_ready;
  // A redirect cancels the response of the previous cycle's fetch.
  assign push        = inflight & ~redirect_valid;
  assign push_entry  = '{pc: inflight_pc, instr: imem_data};

  // Slots already claimed once this cycle's pop is accounted for; a redirect frees them all.
  assign occupancy = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
  assign issue     = run & (redirect_valid | (occupancy < OCC_W'(BUF_DEPTH)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= FETCH_RUNNING;
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      state    <= state_next;
      inflight <= issue;
      if (issue) begin
        inflight_pc <= imem_sel;
        fetch_pc    <= next_pc(imem_sel);
      end else if (redirect_valid) begin
        fetch_pc <= redirect_target;
      end
    end
  end

  always_comb begin
    state_next = state;
    halted     = 1'b0;
    case (state)
      FETCH_RUNNING: begin
        if (!run) state_next = FETCH_HOLD;
      end
      FETCH_HOLD: begin
        halted = !inflight && (count == '0);
        if (run) state_next = FETCH_RUNNING;
      end
      default: state_next = FETCH_RUNNING;
    endcase
  end

  assign fsm_state = state;

  instruction_fetch_controller_fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .CNT_W (CNT_W)
  ) u_fetch_buffer (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (count),
    .head       (head)
  );

  assign instr    = head.instr;
  assign instr_pc = head.pc;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Bench for instruction_fetch_controller paired with a behavioural registered-read memory.
// Expected pc stream kept as a queue; a negedge monitor checks every accepted instruction.
module tb_instruction_fetch_controller;
  import instruction_fetch_controller_pkg::*;

  logic         clock = 1'b0;
  logic         reset;
  logic         run;
  logic [31:0]  imem_sel;
  logic [31:0]  imem_data = '0;
  logic         redirect_valid;
  logic [31:0]  redirect_target;
  logic         instr_valid;
  logic         instr_ready;
  logic [31:0]  instr;
  logic [31:0]  instr_pc;
  logic         halted;
  fetch_state_t fsm_state;

  int n_checks = 0;
  int n_errors = 0;
  int n_pops = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_next;
  logic [31:0] sb_e;

  instruction_fetch_controller dut (
    .clock           (clock),
    .reset           (reset),
    .run             (run),
    .imem_sel        (imem_sel),
    .imem_data       (imem_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .halted          (halted),
    .fsm_state       (fsm_state)
  );

  // clock / reset-free memory model
  always #5 clock = ~clock;

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    logic [31:0] h;
    h = (pc * 32'h9E37_79B1) ^ 32'h1234_5678;
    return {(pc[0] ? OP_BEQ : OP_R), h[25:6] ^ pc[19:0], OPR_ADD};
  endfunction

  always @(posedge clock) imem_data <= word_at(imem_sel);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: the pc stream decode must see, topped up ahead of the monitor
  task automatic top_up();
    while (exp_q.size() < 8) begin
      exp_q.push_back(model_next);
      model_next = model_next + 32'd1;
    end
  endtask

  task automatic restart_model(input logic [31:0] pc);
    exp_q.delete();
    model_next = pc;
    top_up();
  endtask

  // driver: inputs change 1 time unit after posedge; model updated after that cycle's negedge
  task automatic drive(input logic r, input logic rdy, input logic rv, input logic [31:0] tgt);
    @(posedge clock);
    #1;
    run = r;
    instr_ready = rdy;
    redirect_valid = rv;
    redirect_target = tgt;
    @(negedge clock);
    #1;
    if (rv) restart_model(tgt);
    top_up();
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (!reset && instr_valid && instr_ready) begin
      n_pops++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: got pc %h expected none", instr_pc);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_pc", instr_pc, sb_e);
        check("sb_instr", instr, word_at(sb_e));
      end
    end
  end

  initial begin
    logic got;
    logic r, rdy, rv;
    logic [31:0] tgt;
    int pops_start;

    reset = 1'b1;
    run = 1'b0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", instr_pc, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_sel", imem_sel, 32'd0);

    restart_model(32'd0);
    run = 1'b1;
    instr_ready = 1'b1;
    reset = 1'b0;

    drive(1, 1, 0, 0);
    check("first_valid_low", 32'(instr_valid), 32'd0);
    drive(1, 1, 0, 0);
    check("first_valid_high", 32'(instr_valid), 32'd1);
    check("first_pc", instr_pc, 32'd0);

    // decode stall with pc 1 at the head
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0);
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_pc", instr_pc, 32'd1);
      check("stall_instr", instr, word_at(32'd1));
      check("stall_sel", imem_sel, 32'd3);
    end
    drive(1, 1, 0, 0);
    check("release_pc", instr_pc, 32'd1);
    for (int k = 2; k <= 4; k++) begin
      drive(1, 1, 0, 0);
      check("release_valid", 32'(instr_valid), 32'd1);
      check("release_seq_pc", instr_pc, 32'(k));
    end

    drive(1, 1, 0, 0);
    drive(1, 1, 1, 32'd0);
    check("redir_head_pc", instr_pc, 32'd6);
    drive(1, 1, 0, 0);
    check("redir_bubble", 32'(instr_valid), 32'd0);
    drive(1, 1, 0, 0);
    check("redir_first_valid", 32'(instr_valid), 32'd1);
    check("redir_first_pc", instr_pc, 32'd0);

    // back-to-back redirects: 8 then 2
    drive(1, 1, 1, 32'd8);
    drive(1, 1, 1, 32'd2);
    check("b2b_bubble1", 32'(instr_valid), 32'd0);
    drive(1, 1, 0, 0);
    check("b2b_bubble2", 32'(instr_valid), 32'd0);
    drive(1, 1, 0, 0);
    check("b2b_pc", instr_pc, 32'd2);
    drive(1, 1, 0, 0);

    // run deassert: in-flight word lands, buffer drains, then halted
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 0, 0);
      if (halted) begin
        got = 1'b1;
        break;
      end
    end
    check("halt_reached", 32'(got), 32'd1);
    check("halt_valid", 32'(instr_valid), 32'd0);
    check("halt_sel", imem_sel, 32'd6);
    repeat (4) drive(1, 1, 0, 0);
    check("resume_pc", instr_pc, 32'd7);
    check("resume_unhalted", 32'(halted), 32'd0);

    // asynchronous reset between edges with a fetch in flight
    #2;
    reset = 1'b1;
    #1;
    check("async_valid", 32'(instr_valid), 32'd0);
    check("async_instr", instr, 32'd0);
    check("async_pc", instr_pc, 32'd0);
    check("async_sel", imem_sel, 32'd0);
    restart_model(32'd0);
    @(posedge clock);
    @(negedge clock);
    #1;
    reset = 1'b0;
    drive(1, 1, 0, 0);
    drive(1, 1, 0, 0);
    check("post_reset_pc", instr_pc, 32'd0);
    check("post_reset_valid", 32'(instr_valid), 32'd1);

    // word index wrap
    drive(1, 1, 1, 32'hFFFF_FFFE);
    repeat (4) drive(1, 1, 0, 0);
    check("wrap_pc", instr_pc, 32'd0);

    // randomized traffic
    pops_start = n_pops;
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 19) != 0);
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 24) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3)))
                                        : 32'($urandom_range(0, 1000));
      drive(r, rdy, rv, tgt);
    end
    repeat (4) drive(1, 1, 0, 0);
    check("random_progress", 32'(n_pops - pops_start >= 120), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
